// File: rtl/rv_timer_mc_pkg.sv
// Shared definitions for the multi-hart / multi-comparator timer core.
// Holds the default parameter values and a per-comparator configuration
// struct the register block can use to bundle what it drives into a
// comparator (compare value, auto-reload enable, reload increment).
package rv_timer_mc_pkg;

  localparam int NUM_HARTS_DEF  = 2;
  localparam int NUM_TIMERS_DEF = 2;
  localparam int CNT_W_DEF      = 64;
  localparam int PRESC_W_DEF    = 12;
  localparam int STEP_W_DEF     = 8;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] cmp;
    logic                 periodic;
    logic [CNT_W_DEF-1:0] period;
  } cmp_cfg_t;

endpackage

// File: rtl/rv_timer_cmp_unit.sv
// Single comparator: compare register, optional periodic auto-reload and
// rising-edge event generation.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   mtime_i          current mtime of the owning hart
//   cmp_we_i/wdata   compare register load
//   periodic_i       auto-reload enable
//   period_i         reload increment (0 disables reload)
//   cmp_o            current compare value
//   expired_o        level, mtime >= cmp (unsigned)
//   event_o          one-cycle pulse on rising edge of expired_o
module rv_timer_cmp_unit import rv_timer_mc_pkg::*; #(
  parameter int CntW = CNT_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [CntW-1:0] mtime_i,
  input  logic            cmp_we_i,
  input  logic [CntW-1:0] cmp_wdata_i,
  input  logic            periodic_i,
  input  logic [CntW-1:0] period_i,
  output logic [CntW-1:0] cmp_o,
  output logic            expired_o,
  output logic            event_o
);

  logic [CntW-1:0] cmp_q, cmp_d;
  logic            expired_q, expired_d;
  logic            expired;

  always_comb begin
    expired   = (mtime_i >= cmp_q);
    cmp_d     = cmp_q;
    expired_d = expired;
    if (cmp_we_i) begin
      cmp_d     = cmp_wdata_i;
      // Clearing the edge history lets a re-arm to an already-passed value
      // still produce an event on the next cycle.
      expired_d = 1'b0;
    end else if (expired && periodic_i && (period_i != '0)) begin
      // One period per cycle; a far-behind cmp catches up while expired
      // stays high, so only one event fires for the whole run.
      cmp_d = cmp_q + period_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_q     <= '1;
      expired_q <= 1'b0;
    end else begin
      cmp_q     <= cmp_d;
      expired_q <= expired_d;
    end
  end

  assign cmp_o     = cmp_q;
  assign expired_o = expired;
  assign event_o   = expired & ~expired_q;

endmodule

// File: rtl/rv_timer_core_mc.sv
// Multi-hart timer core. Each hart owns a prescaler and an mtime counter;
// each hart feeds NumTimers comparator units. Flattened comparator vectors
// are indexed h*NumTimers+t.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   active_i            per-hart counter enable
//   prescaler_i/step_i  per-hart tick divider and mtime increment
//   mtime_we_i/wdata_i  per-hart mtime load (wins over tick increment)
//   mtime_o, tick_o     per-hart counter value and tick strobe
//   cmp_*, periodic_i,
//   period_i            per-comparator compare load and auto-reload config
//   cmp_o, expired_o,
//   event_o             per-comparator compare value, level and edge pulse
module rv_timer_core_mc import rv_timer_mc_pkg::*; #(
  parameter int NumHarts  = NUM_HARTS_DEF,
  parameter int NumTimers = NUM_TIMERS_DEF,
  parameter int CntW      = CNT_W_DEF,
  parameter int PrescW    = PRESC_W_DEF,
  parameter int StepW     = STEP_W_DEF
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumHarts-1:0]                active_i,
  input  logic [NumHarts*PrescW-1:0]         prescaler_i,
  input  logic [NumHarts*StepW-1:0]          step_i,
  input  logic [NumHarts-1:0]                mtime_we_i,
  input  logic [NumHarts*CntW-1:0]           mtime_wdata_i,
  output logic [NumHarts*CntW-1:0]           mtime_o,
  output logic [NumHarts-1:0]                tick_o,
  input  logic [NumHarts*NumTimers-1:0]      cmp_we_i,
  input  logic [NumHarts*NumTimers*CntW-1:0] cmp_wdata_i,
  output logic [NumHarts*NumTimers*CntW-1:0] cmp_o,
  input  logic [NumHarts*NumTimers-1:0]      periodic_i,
  input  logic [NumHarts*NumTimers*CntW-1:0] period_i,
  output logic [NumHarts*NumTimers-1:0]      expired_o,
  output logic [NumHarts*NumTimers-1:0]      event_o
);

  for (genvar h = 0; h < NumHarts; h++) begin : g_hart
    logic [PrescW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0]   mtime_q, mtime_d;
    logic              tick;

    always_comb begin
      // A prescaler lowered below the running count is not special-cased:
      // the count wraps at 2^PrescW and matches on the way round.
      tick    = active_i[h] && (cnt_q == prescaler_i[h*PrescW +: PrescW]);
      cnt_d   = cnt_q + PrescW'(1);
      if (!active_i[h] || tick) cnt_d = '0;
      mtime_d = mtime_q;
      if (mtime_we_i[h])
        mtime_d = mtime_wdata_i[h*CntW +: CntW];
      else if (tick)
        mtime_d = mtime_q + CntW'(step_i[h*StepW +: StepW]);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q   <= '0;
        mtime_q <= '0;
      end else begin
        cnt_q   <= cnt_d;
        mtime_q <= mtime_d;
      end
    end

    assign tick_o[h]                = tick;
    assign mtime_o[h*CntW +: CntW] = mtime_q;

    for (genvar t = 0; t < NumTimers; t++) begin : g_tmr
      localparam int Idx = h*NumTimers + t;

      rv_timer_cmp_unit #(.CntW(CntW)) u_cmp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mtime_i     (mtime_q),
        .cmp_we_i    (cmp_we_i[Idx]),
        .cmp_wdata_i (cmp_wdata_i[Idx*CntW +: CntW]),
        .periodic_i  (periodic_i[Idx]),
        .period_i    (period_i[Idx*CntW +: CntW]),
        .cmp_o       (cmp_o[Idx*CntW +: CntW]),
        .expired_o   (expired_o[Idx]),
        .event_o     (event_o[Idx])
      );
    end
  end

endmodule

// File: tb/tb_rv_timer_core_mc.sv
// Directed bench for rv_timer_core_mc with default parameters
// (2 harts x 2 comparators, 64-bit counters).
module tb_rv_timer_core_mc;

  localparam int NH = 2;
  localparam int NT = 2;
  localparam int CW = 64;
  localparam int PW = 12;
  localparam int SW = 8;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NH-1:0]     active_i;
  logic [NH*PW-1:0]  prescaler_i;
  logic [NH*SW-1:0]  step_i;
  logic [NH-1:0]     mtime_we_i;
  logic [NH*CW-1:0]  mtime_wdata_i;
  logic [NH*CW-1:0]  mtime_o;
  logic [NH-1:0]     tick_o;
  logic [NH*NT-1:0]  cmp_we_i;
  logic [NH*NT*CW-1:0] cmp_wdata_i;
  logic [NH*NT*CW-1:0] cmp_o;
  logic [NH*NT-1:0]  periodic_i;
  logic [NH*NT*CW-1:0] period_i;
  logic [NH*NT-1:0]  expired_o;
  logic [NH*NT-1:0]  event_o;

  int n_checks = 0;
  int n_err    = 0;
  int pulses;

  always #5 clk = ~clk;

  rv_timer_core_mc #(.NumHarts(NH), .NumTimers(NT), .CntW(CW),
                     .PrescW(PW), .StepW(SW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .active_i      (active_i),
    .prescaler_i   (prescaler_i),
    .step_i        (step_i),
    .mtime_we_i    (mtime_we_i),
    .mtime_wdata_i (mtime_wdata_i),
    .mtime_o       (mtime_o),
    .tick_o        (tick_o),
    .cmp_we_i      (cmp_we_i),
    .cmp_wdata_i   (cmp_wdata_i),
    .cmp_o         (cmp_o),
    .periodic_i    (periodic_i),
    .period_i      (period_i),
    .expired_o     (expired_o),
    .event_o       (event_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the last edge.
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; active_i = '0; prescaler_i = '0; step_i = '0;
    mtime_we_i = '0; mtime_wdata_i = '0; cmp_we_i = '0; cmp_wdata_i = '0;
    periodic_i = '0; period_i = '0;
    cyc(2);
    rst_i = 1'b0;

    // Idle after reset
    cyc(20);
    chk("rst_mtime0", mtime_o[63:0], 64'd0);
    chk("rst_mtime1", mtime_o[127:64], 64'd0);
    chk("rst_tick", 64'(tick_o), 64'd0);
    for (int k = 0; k < NH*NT; k++) chk("rst_cmp", cmp_o[k*CW +: CW], '1);
    chk("rst_expired", 64'(expired_o), 64'd0);
    chk("rst_event", 64'(event_o), 64'd0);

    // Prescaler 3, step 5 on hart0: tick every 4th cycle
    prescaler_i[11:0] = 12'd3; step_i[7:0] = 8'd5; active_i[0] = 1'b1;
    cyc(3);
    chk("presc_tick", 64'(tick_o), 64'd1);
    cyc(1);
    chk("presc_mt5", mtime_o[63:0], 64'd5);
    cyc(8);
    chk("presc_mt15", mtime_o[63:0], 64'd15);
    chk("presc_h1", mtime_o[127:64], 64'd0);
    chk("presc_notick", 64'(tick_o), 64'd0);

    // One-shot at 10
    active_i[0] = 1'b0; prescaler_i[11:0] = 12'd0; step_i[7:0] = 8'd1;
    mtime_we_i[0] = 1'b1; mtime_wdata_i[63:0] = 64'd0;
    cmp_we_i[0] = 1'b1; cmp_wdata_i[63:0] = 64'd10;
    cyc();
    mtime_we_i[0] = 1'b0; cmp_we_i[0] = 1'b0; active_i[0] = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("os_evt", 64'(event_o[0]), 64'(i == 10));
      pulses += int'(event_o[0]);
    end
    chk("os_mtime", mtime_o[63:0], 64'd12);
    chk("os_level", 64'(expired_o[0]), 64'd1);
    chk("os_pulses", 64'(pulses), 64'd1);
    // Re-arm to 20
    cmp_we_i[0] = 1'b1; cmp_wdata_i[63:0] = 64'd20;
    cyc();
    cmp_we_i[0] = 1'b0;
    chk("rearm_level", 64'(expired_o[0]), 64'd0);
    chk("rearm_cmp", cmp_o[63:0], 64'd20);
    for (int i = 14; i <= 23; i++) begin
      cyc();
      chk("rearm_evt", 64'(event_o[0]), 64'(i == 20));
    end

    // Periodic, cmp=8 period=8
    active_i[0] = 1'b0;
    mtime_we_i[0] = 1'b1; mtime_wdata_i[63:0] = 64'd0;
    cmp_we_i[0] = 1'b1; cmp_wdata_i[63:0] = 64'd8;
    periodic_i[0] = 1'b1; period_i[63:0] = 64'd8;
    cyc();
    mtime_we_i[0] = 1'b0; cmp_we_i[0] = 1'b0; active_i[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      chk("per_evt", 64'(event_o[0]), 64'(i == 8 || i == 16 || i == 24));
      chk("per_cmp", cmp_o[63:0], 64'(((i + 7) / 8) * 8));
    end

    // mtime write beats a tick in the same cycle
    mtime_we_i[0] = 1'b1; mtime_wdata_i[63:0] = 64'd1000;
    cyc();
    mtime_we_i[0] = 1'b0; active_i[0] = 1'b0;
    chk("prio_mtime", mtime_o[63:0], 64'd1000);
    // cmp write beats a pending periodic reload (cmp=32 expired here)
    chk("prio_pre", 64'(expired_o[0]), 64'd1);
    cmp_we_i[0] = 1'b1; cmp_wdata_i[63:0] = 64'd2000;
    cyc();
    cmp_we_i[0] = 1'b0; periodic_i[0] = 1'b0;
    chk("prio_cmp", cmp_o[63:0], 64'd2000);
    // mtime wrap
    mtime_we_i[0] = 1'b1; mtime_wdata_i[63:0] = 64'hFFFF_FFFF_FFFF_FFFE; step_i[7:0] = 8'd3;
    cyc();
    mtime_we_i[0] = 1'b0; active_i[0] = 1'b1;
    cyc();
    active_i[0] = 1'b0;
    chk("wrap_mtime", mtime_o[63:0], 64'd1);

    // Re-arm into the past with periodic catch-up
    mtime_we_i[0] = 1'b1; mtime_wdata_i[63:0] = 64'd100;
    cyc();
    mtime_we_i[0] = 1'b0;
    cmp_we_i[0] = 1'b1; cmp_wdata_i[63:0] = 64'd50;
    periodic_i[0] = 1'b1; period_i[63:0] = 64'd10;
    cyc();
    cmp_we_i[0] = 1'b0;
    chk("cu_evt", 64'(event_o[0]), 64'd1);
    chk("cu_cmp0", cmp_o[63:0], 64'd50);
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("cu_cmp", cmp_o[63:0], 64'(50 + 10 * i));
      pulses += int'(event_o[0]);
    end
    chk("cu_pulses", 64'(pulses), 64'd0);
    chk("cu_level", 64'(expired_o[0]), 64'd0);
    chk("cu_mtime", mtime_o[63:0], 64'd100);

    // Simultaneous mtime and cmp write on hart1, comparator 0
    mtime_we_i[1] = 1'b1; mtime_wdata_i[127:64] = 64'd5;
    cmp_we_i[2] = 1'b1; cmp_wdata_i[191:128] = 64'd5;
    cyc();
    mtime_we_i[1] = 1'b0; cmp_we_i[2] = 1'b0;
    chk("sim_mtime1", mtime_o[127:64], 64'd5);
    chk("sim_level", 64'(expired_o[2]), 64'd1);
    chk("sim_evt", 64'(event_o[2]), 64'd1);
    chk("sim_other", 64'(expired_o[3]), 64'd0);

    // Reset mid-count
    periodic_i = '0; active_i[0] = 1'b1; step_i[7:0] = 8'd1;
    cyc(3);
    rst_i = 1'b1; active_i = '0;
    cyc();
    chk("mid_mtime0", mtime_o[63:0], 64'd0);
    chk("mid_mtime1", mtime_o[127:64], 64'd0);
    chk("mid_cmp0", cmp_o[63:0], '1);
    chk("mid_cmp2", cmp_o[191:128], '1);
    chk("mid_level", 64'(expired_o), 64'd0);
    chk("mid_event", 64'(event_o), 64'd0);
    chk("mid_tick", 64'(tick_o), 64'd0);
    rst_i = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
